// File: rtl/leve_ifq.sv
// leve_ifq -- instruction fetch queue between the instruction burst buffer
// and decode. Circular buffer of DEPTH {PC, INST} entries with separate write
// and read pointers and an occupancy counter.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   FLUSH                     branch redirect: drop every queued entry
//   IN_VALID/IN_READY         upstream handshake, IN_PC/IN_INST payload
//   OUT_VALID/OUT_READY       decode handshake, OUT_PC/OUT_INST = head entry
//   COUNT                     number of occupied entries (0..DEPTH)
//
// Build option:
//   LEVE_IFQ_BYPASS_EN        when defined, an empty queue forwards the
//                             upstream offer straight to decode in the same
//                             cycle; otherwise OUT_* comes only from storage.
//
// Storage is deliberately not reset: only pointers and COUNT are cleared by
// RST or FLUSH, so the stale contents are never visible (OUT_VALID is 0).

`ifndef XLEN
`define XLEN 32
`endif

module leve_ifq #(
    parameter int DEPTH = 4,
    parameter int IW    = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FLUSH,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [`XLEN-1:0]         IN_PC,
    input  logic [IW-1:0]            IN_INST,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [`XLEN-1:0]         OUT_PC,
    output logic [IW-1:0]            OUT_INST,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [`XLEN-1:0] pc;
        logic [IW-1:0]    inst;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic empty, full, push, pop, bypass;
    entry_t head;

    // Handshake and output selection
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        head     = mem_q[rd_ptr_q];
        // RST gating keeps both handshakes low for the whole reset pulse;
        // IN_READY never looks at OUT_READY, so full stays not-ready even
        // when decode pops in the same cycle.
        IN_READY = !full && !FLUSH && !RST;
`ifdef LEVE_IFQ_BYPASS_EN
        // Empty queue: present the upstream offer directly. If decode takes
        // it now, it never touches storage.
        OUT_VALID = (!empty || IN_VALID) && !FLUSH && !RST;
        OUT_PC    = empty ? IN_PC   : head.pc;
        OUT_INST  = empty ? IN_INST : head.inst;
        bypass    = empty && IN_VALID && OUT_READY && !FLUSH && !RST;
`else
        OUT_VALID = !empty && !FLUSH && !RST;
        OUT_PC    = head.pc;
        OUT_INST  = head.inst;
        bypass    = 1'b0;
`endif
        push  = IN_VALID && IN_READY && !bypass;
        pop   = OUT_VALID && OUT_READY && !bypass;
        COUNT = count_q;
    end

    // Next state; FLUSH overrides any push/pop in the same cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: IN_PC, inst: IN_INST};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/leve_ifq.md
LEVE_IFQ -- requirements
Module: leve_ifq

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter IW, default 32: instruction width in bits.
REQ-003 CLK  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 RST  in  1  reset, asynchronous and active-high.
REQ-005 FLUSH  in  1  discards all queued entries (branch redirect).
REQ-006 IN_VALID  in  1  upstream (instruction burst buffer) offers an entry.
REQ-007 IN_READY  out  1  queue accepts an entry this cycle.
REQ-008 IN_PC  in  `XLEN  PC of the offered instruction.
REQ-009 IN_INST  in  IW  offered instruction word.
REQ-010 OUT_VALID  out  1  head entry available to decode.
REQ-011 OUT_READY  in  1  decode consumes the head this cycle.
REQ-012 OUT_PC  out  `XLEN  PC of the head entry.
REQ-013 OUT_INST  out  IW  instruction word of the head entry.
REQ-014 COUNT  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 Push SHALL occur when IN_VALID && IN_READY; pop SHALL occur when OUT_VALID && OUT_READY.
REQ-016 Storage SHALL be a circular buffer of DEPTH {PC, INST} entries with write and read pointers, each incrementing modulo DEPTH on push and pop respectively.
REQ-017 IN_READY SHALL equal (COUNT < DEPTH) && !FLUSH, with no combinational path from OUT_READY.
REQ-018 OUT_VALID SHALL equal (COUNT != 0) && !FLUSH when bypass is compiled out.
REQ-019 OUT_PC/OUT_INST SHALL present the entry at the read pointer, and SHALL stay stable while OUT_VALID && !OUT_READY.
REQ-020 Without bypass, latency from a push to OUT_VALID SHALL be exactly 1 cycle.
REQ-021 COUNT updates:
  - push without pop: +1.
  - pop without push: -1.
  - simultaneous push and pop: unchanged.
REQ-022 Full (COUNT == DEPTH): IN_READY SHALL be 0 even if a pop occurs the same cycle.
REQ-023 Empty (COUNT == 0): no pop SHALL occur; pointers SHALL hold.
REQ-024 FLUSH high at a clock edge:
  - COUNT and both pointers SHALL be 0 after that edge.
  - any push or pop in that cycle SHALL be suppressed.
  - FLUSH SHALL take priority over all other events.
REQ-025 Entry contents SHALL NOT be cleared by FLUSH or RST; only pointers and COUNT are reset.

Reset
REQ-026 On RST assertion, asynchronously: COUNT = 0, pointers = 0, OUT_VALID = 0, IN_READY = 0.
REQ-027 While RST is high, IN_READY and OUT_VALID SHALL remain 0.
REQ-028 RST asserted mid-operation SHALL drop all entries, identically to FLUSH but immediately.
REQ-029 After deassertion, IN_READY SHALL be 1 from the first cycle.

Configuration
REQ-030 Macro LEVE_IFQ_BYPASS_EN controls the empty-queue bypass.
REQ-031 With LEVE_IFQ_BYPASS_EN defined and COUNT == 0 && !FLUSH:
  - OUT_VALID SHALL equal IN_VALID.
  - OUT_PC/OUT_INST SHALL equal IN_PC/IN_INST.
  - if OUT_READY = 1, the entry passes through with 0-cycle latency and is not written (COUNT stays 0).
  - if OUT_READY = 0, the entry is pushed normally.
REQ-032 Without LEVE_IFQ_BYPASS_EN, REQ-018 and REQ-020 SHALL apply unchanged; no combinational path from IN_* to OUT_* SHALL exist.

Verification
REQ-033 Fill: OUT_READY=0, push PCs 0x1000, 0x1004, 0x1008, 0x100C -> COUNT=4, IN_READY=0; a fifth offer is not accepted.
REQ-034 Order and wrap: push 6 entries while popping, then drain -> OUT_PC sequence 0x1000..0x1014 in order; pointers wrap without loss.
REQ-035 Simultaneous: COUNT=2, push and pop in the same cycle -> COUNT stays 2; head advances to the next PC.
REQ-036 Flush: COUNT=3, FLUSH=1 with IN_VALID=1 -> OUT_VALID=0 and IN_READY=0 that cycle; COUNT=0 next cycle; the offered entry is lost.
REQ-037 Reset: RST pulsed mid-cycle with COUNT=2 -> COUNT=0 and OUT_VALID=0 immediately, without a clock edge.
REQ-038 Bypass: with macro defined, empty queue, IN_VALID=1, IN_INST=0x00000013, OUT_READY=1 -> OUT_VALID=1 and OUT_INST=0x00000013 the same cycle; COUNT stays 0. Without the macro, OUT_VALID asserts one cycle later.
